if_id_fetch_buffer: RTL and testbench

- Decoupling stage directly downstream of the IF program-counter register.
- Captures each fetched {PC, instruction} pair into a small FIFO and presents the head to the ID stage.
- Back-pressures the PC register through its stall input when full.
- Discards all in-flight fetches on a control-flow flush from EX.

---
 rtl/if_id_fetch_buffer_pkg.sv | 13 +
 rtl/if_id_fetch_buffer_fetch_fifo.sv | 77 +++++++
 rtl/if_id_fetch_buffer.sv | 57 +++++
 tb/tb_if_id_fetch_buffer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_fetch_buffer_pkg.sv
// Shared IF/ID pipeline types and constants.
// The buffered fetch entry is a packed {pc, instr} pair.
package if_id_fetch_buffer_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_id_entry_t;

endpackage

// File: rtl/if_id_fetch_buffer_fetch_fifo.sv
// Generic DEPTH x WIDTH circular FIFO with first-word fall-through read data.
// The write is visible one cycle later. Push is ignored when full, pop when empty, and clear wins over both.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_dat,
   input  logic             i_pop,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_rd_dat,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign o_full   = (count_q == CNT_W'(DEPTH));
   assign o_empty  = (count_q == '0);
   assign push_ok  = i_push & ~o_full;
   assign pop_ok   = i_pop & ~o_empty;
   assign o_rd_dat = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (i_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = i_wr_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/if_id_fetch_buffer.sv
// IF->ID decoupling buffer: a fetched {pc, instr} pair reaches ID one cycle after capture.
// Stalls the PC register from registered fullness only, and an EX flush kills everything.
module if_id_fetch_buffer
   import if_id_fetch_buffer_pkg::*;
#(
   parameter int              DEPTH     = 2,
   parameter logic [XLEN-1:0] NOP_INSTR = if_id_fetch_buffer_pkg::NOP_INSTR
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic [XLEN-1:0] i_pc_if,
   input  logic [XLEN-1:0] i_instr_if,
   input  logic            i_valid_if,
   input  logic            i_stall_id,
   input  logic            i_flush,
   output logic [XLEN-1:0] o_pc_id,
   output logic [XLEN-1:0] o_pc4_id,
   output logic [XLEN-1:0] o_instr_id,
   output logic            o_valid_id,
   output logic            o_stall_if
);

   if_id_entry_t wr_entry;
   if_id_entry_t head;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;

   assign wr_entry = '{pc: i_pc_if, instr: i_instr_if};

   // Flush dominates: no push or pop is issued in the flush cycle.
   assign push = i_valid_if & ~full & ~i_flush;
   assign pop  = o_valid_id & ~i_stall_id & ~i_flush;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(if_id_entry_t))
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (push),
      .i_wr_dat  (wr_entry),
      .i_pop     (pop),
      .i_clear   (i_flush),
      .o_rd_dat  (head),
      .o_full    (full),
      .o_empty   (empty)
   );

   assign o_valid_id = ~empty;
   assign o_stall_if = full;
   assign o_pc_id    = o_valid_id ? head.pc : '0;
   assign o_instr_id = o_valid_id ? head.instr : NOP_INSTR;
   assign o_pc4_id   = o_pc_id + 32'd4;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Randomised bench for if_id_fetch_buffer against a queue-based reference model.
module tb_if_id_fetch_buffer;
   import if_id_fetch_buffer_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_pc_if = '0;
   logic [31:0] i_instr_if = '0;
   logic        i_valid_if = 1'b0;
   logic        i_stall_id = 1'b0;
   logic        i_flush = 1'b0;
   logic [31:0] o_pc_id, o_pc4_id, o_instr_id;
   logic        o_valid_id, o_stall_if;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t mq[$];

   if_id_fetch_buffer #(.DEPTH(DEPTH)) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_pc_if    (i_pc_if),
      .i_instr_if (i_instr_if),
      .i_valid_if (i_valid_if),
      .i_stall_id (i_stall_id),
      .i_flush    (i_flush),
      .o_pc_id    (o_pc_id),
      .o_pc4_id   (o_pc4_id),
      .o_instr_id (o_instr_id),
      .o_valid_id (o_valid_id),
      .o_stall_if (o_stall_if)
   );

   always #5 clk = ~clk;

   wire [97:0] act_vec = {o_valid_id, o_stall_if, o_pc_id, o_instr_id, o_pc4_id};
   localparam logic [97:0] RST_VEC = {1'b0, 1'b0, 32'h0, 32'h0000_0013, 32'h4};

   // Expected outputs: head of the model queue, or the idle NOP view when empty.
   function automatic logic [97:0] exp_vec();
      logic        v, s;
      logic [31:0] pc, ins;
      v   = (mq.size() != 0);
      s   = (mq.size() == DEPTH);
      pc  = v ? mq[0].pc : 32'h0;
      ins = v ? mq[0].instr : 32'h0000_0013;
      return {v, s, pc, ins, pc + 32'd4};
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
      i_valid_if = v;
      i_pc_if    = pc;
      i_instr_if = ins;
      i_stall_id = st;
      i_flush    = fl;
   endtask

   // Advance one clock, applying the buffer rules to the model first.
   task automatic tick();
      logic was_full, was_vld;
      was_full = (mq.size() == DEPTH);
      was_vld  = (mq.size() != 0);
      if (!rst_n || i_flush) begin
         mq.delete();
      end else begin
         if (was_vld && !i_stall_id) void'(mq.pop_front());
         if (i_valid_if && !was_full) mq.push_back('{pc: i_pc_if, instr: i_instr_if});
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (dut.u_fifo.count_q > DEPTH || (dut.push && dut.full) || (dut.pop && !o_valid_id)) begin
            n_fail++;
            $display("FAIL occupancy_rules: count=%0d push=%b full=%b pop=%b valid=%b",
                     dut.u_fifo.count_q, dut.push, dut.full, dut.pop, o_valid_id);
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      mq.delete();
      for (int c = 0; c < 3; c++) begin
         drive($urandom_range(0, 1), $urandom(), $urandom(), $urandom_range(0, 1), $urandom_range(0, 1));
         #1;
         n_checks++;
         if (act_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset cyc%0d: got %h want %h", c, act_vec, RST_VEC);
         end
         tick();
      end
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (act_vec !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_release: got %h want %h", act_vec, RST_VEC);
      end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'(i * 4), 32'hA + 32'(i), 0, 0);
         #1;
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL streaming cyc%0d: got %h want %h", i, act_vec, exp_vec());
         end
         tick();
      end
      drive(0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (o_valid_id !== 1'b1 || o_pc_id !== 32'h8 || o_instr_id !== 32'hC || o_stall_if !== 1'b0) begin
         n_fail++;
         $display("FAIL streaming_last: got v=%b pc=%h ins=%h st=%b want v=1 pc=8 ins=c st=0",
                  o_valid_id, o_pc_id, o_instr_id, o_stall_if);
      end
      tick();
      n_checks++;
      if (act_vec !== RST_VEC) begin
         n_fail++;
         $display("FAIL streaming_drain: got %h want %h", act_vec, RST_VEC);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [3];
      logic [31:0] ins [3];
      logic [31:0] got [$];
      int          idx;
      logic        st, acc;
      pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
      for (int k = 0; k < 3; k++) ins[k] = $urandom();
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         st = (c < 4);
         if (idx < 3) drive(1, pcs[idx], ins[idx], st, 0);
         else drive(0, 0, 0, st, 0);
         #1;
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL backpressure cyc%0d: got %h want %h", c, act_vec, exp_vec());
         end
         if (c == 2) begin
            n_checks++;
            if (o_stall_if !== 1'b1) begin
               n_fail++;
               $display("FAIL backpressure_full: got stall=%b want 1", o_stall_if);
            end
         end
         if (o_valid_id && !st) got.push_back(o_pc_id);
         acc = (idx < 3) && (mq.size() < DEPTH);
         tick();
         if (acc) idx++;
      end
      n_checks++;
      if (got.size() != 3) begin
         n_fail++;
         $display("FAIL backpressure_count: got %0d pops want 3", got.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (got[k] !== pcs[k]) begin
               n_fail++;
               $display("FAIL backpressure_order%0d: got %h want %h", k, got[k], pcs[k]);
            end
         end
      end
   endtask

   task automatic test_flush();
      drive(1, 32'h10, $urandom(), 1, 0); tick();
      drive(1, 32'h14, $urandom(), 1, 0); tick();
      drive(1, 32'h18, $urandom(), 1, 1);
      #1;
      n_checks++;
      if (act_vec !== exp_vec() || o_pc_id !== 32'h10) begin
         n_fail++;
         $display("FAIL flush_pre: got %h want %h", act_vec, exp_vec());
      end
      tick();
      drive(1, 32'h40, 32'h1234_5678, 0, 0);
      #1;
      n_checks++;
      if (o_valid_id !== 1'b0 || o_stall_if !== 1'b0 || o_instr_id !== 32'h13) begin
         n_fail++;
         $display("FAIL flush_post: got v=%b st=%b ins=%h want v=0 st=0 ins=13", o_valid_id, o_stall_if, o_instr_id);
      end
      tick();
      drive(0, 0, 0, 1, 0);
      #1;
      n_checks++;
      if (o_valid_id !== 1'b1 || o_pc_id !== 32'h40 || o_instr_id !== 32'h1234_5678 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL flush_refill: got v=%b pc=%h ins=%h want v=1 pc=40 ins=12345678", o_valid_id, o_pc_id, o_instr_id);
      end
      drive(0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_pc4_wrap();
      drive(1, 32'hFFFF_FFFC, 32'h0000_0067, 1, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (o_pc_id !== 32'hFFFF_FFFC || o_pc4_id !== 32'h0) begin
         n_fail++;
         $display("FAIL pc4_wrap: got pc=%h pc4=%h want pc=fffffffc pc4=0", o_pc_id, o_pc4_id);
      end
      tick();
   endtask

   task automatic test_async_reset();
      drive(1, 32'h100, $urandom(), 1, 0); tick();
      drive(1, 32'h104, $urandom(), 1, 0); tick();
      n_checks++;
      if (o_stall_if !== 1'b1 || act_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL async_fill: got %h want %h", act_vec, exp_vec());
      end
      #2;
      rst_n = 1'b0;
      #1;
      mq.delete();
      n_checks++;
      if (act_vec !== RST_VEC) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got %h want %h", act_vec, RST_VEC);
      end
      tick();
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (act_vec !== RST_VEC) begin
         n_fail++;
         $display("FAIL async_reset_release: got %h want %h", act_vec, RST_VEC);
      end
   endtask

   // PC register emulation: hold the pair while it is refused, redirect on flush.
   task automatic test_random_wrap();
      logic [31:0] cur_pc, cur_ins;
      logic        v, st, fl, acc;
      int          pushes;
      cur_pc  = 32'hFFFF_FFF0;
      cur_ins = $urandom();
      pushes  = 0;
      for (int c = 0; c < 120; c++) begin
         v  = ($urandom_range(0, 3) != 0);
         st = (c % 4 < 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 19) == 0);
         drive(v, cur_pc, cur_ins, st, fl);
         #1;
         n_checks++;
         if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %h want %h", c, act_vec, exp_vec());
         end
         acc = v && !fl && (mq.size() < DEPTH);
         tick();
         if (fl) begin
            cur_pc  = {$urandom()} & 32'hFFFF_FFFC;
            cur_ins = $urandom();
         end else if (acc) begin
            cur_pc  = cur_pc + 32'd4;
            cur_ins = $urandom();
            pushes++;
         end
      end
      n_checks++;
      if (pushes < 7) begin
         n_fail++;
         $display("FAIL random_coverage: got %0d pushes want >= 7", pushes);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_to_back();
      test_flush();
      test_pc4_wrap();
      test_async_reset();
      test_random_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
